// File: rtl/core_sequencer_if.sv
// Memory-side handshake bundle for core_sequencer: instruction fetch and data access ports.
// The master side is the sequencer, and the slave side is the memory system.
interface core_sequencer_if #(parameter int XLEN = 32);
  logic            IMemReq;
  logic [XLEN-1:0] IMemAddr;
  logic            IMemAck;
  logic [15:0]     IMemData;
  logic            DMemReq;
  logic            DMemWe;
  logic [1:0]      DMemSize;
  logic [XLEN-1:0] DMemAddr;
  logic [XLEN-1:0] DMemWdata;
  logic            DMemAck;

  modport master (
    output IMemReq, IMemAddr, DMemReq, DMemWe, DMemSize, DMemAddr, DMemWdata,
    input  IMemAck, IMemData, DMemAck
  );
  modport slave (
    input  IMemReq, IMemAddr, DMemReq, DMemWe, DMemSize, DMemAddr, DMemWdata,
    output IMemAck, IMemData, DMemAck
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM control for the RV32EC compressed datapath.
// Owns the PC, latches instructions for the decoder and sequences regfile writeback and data accesses.
module core_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  core_sequencer_if.master mem,
  output logic [15:0]      Inst,
  input  logic [3:0]       CtrlLSU,
  input  logic             CtrlPCWriteback,
  input  logic [1:0]       CtrlPCMode,
  input  logic [XLEN-1:0]  DecodedImm,
  input  logic [XLEN-1:0]  Rs1Data,
  input  logic [XLEN-1:0]  Rs2Data,
  input  logic [XLEN-1:0]  AluResult,
  input  logic             IntegerUnitFlag,
  output logic             RegWrite,
  output logic [1:0]       RdSrc,
  output logic [XLEN-1:0]  PC,
  output logic             Retire,
  output logic             Halted
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [1:0]  PCINC  = 2'd0;
  localparam logic [1:0]  PCBRCH = 2'd1;
  localparam logic [1:0]  PCJREG = 2'd2;
  localparam logic [1:0]  PCJIMM = 2'd3;
  localparam logic [15:0] EBREAK = 16'h9002;
  localparam logic [15:0] CNOP   = 16'h0001;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_plus2, target, next_pc, pc_n;
  logic            mem_op;
  logic            unused_lsu;

  // Bit 3 of the LSU control has no meaning for the sequencer.
  assign unused_lsu = CtrlLSU[3];
  assign mem_op     = (CtrlLSU[1:0] != 2'b00);
  assign pc_plus2   = PC + XLEN'(2);

  // While reset is high, the state is already FETCH. Gate the request so it stays low during reset.
  assign mem.IMemReq  = (state == S_FETCH) && !rst;
  assign mem.IMemAddr = PC;
  assign mem.DMemReq  = (state == S_MEM);

  always_comb begin
    case (CtrlPCMode)
      PCBRCH:  target = IntegerUnitFlag ? PC + DecodedImm : pc_plus2;
      PCJREG:  target = Rs1Data;
      PCJIMM:  target = PC + DecodedImm;
      default: target = pc_plus2;
    endcase
    next_pc = target & ~XLEN'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    RegWrite = 1'b0;
    RdSrc    = 2'b00;
    Retire   = 1'b0;
    pc_n     = PC;
    case (state)
      S_FETCH: if (mem.IMemAck) state_n = S_EXEC;
      S_EXEC: begin
        if (Inst == EBREAK) state_n = S_HALT;
        else if (mem_op)    state_n = S_MEM;
        else begin
          // Branches, c.nop, and unlinked jumps have no architectural destination register.
          RegWrite = (CtrlPCMode != PCBRCH) && (Inst != CNOP) &&
                     ((CtrlPCMode == PCINC) || CtrlPCWriteback);
          RdSrc    = CtrlPCWriteback ? 2'b10 : 2'b00;
          Retire   = 1'b1;
          pc_n     = next_pc;
          state_n  = S_FETCH;
        end
      end
      S_MEM: if (mem.DMemAck) begin
        RegWrite = !mem.DMemWe;
        RdSrc    = mem.DMemWe ? 2'b00 : 2'b01;
        Retire   = 1'b1;
        pc_n     = pc_plus2;
        state_n  = S_FETCH;
      end
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC            <= RESET_PC;
      Inst          <= CNOP;
      Halted        <= 1'b0;
      mem.DMemWe    <= 1'b0;
      mem.DMemSize  <= 2'b00;
      mem.DMemAddr  <= '0;
      mem.DMemWdata <= '0;
    end else begin
      PC <= pc_n;
      if (state == S_FETCH && mem.IMemAck) Inst <= mem.IMemData;
      if (state == S_EXEC && Inst == EBREAK) Halted <= 1'b1;
      if (state == S_EXEC && Inst != EBREAK && mem_op) begin
        mem.DMemWe    <= CtrlLSU[2];
        mem.DMemSize  <= CtrlLSU[1:0];
        mem.DMemAddr  <= AluResult;
        mem.DMemWdata <= Rs2Data;
      end
    end
  end
endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: the bench acts as memory and decoder, and expected retirements are queued.
module tb_core_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Inst;
  logic [3:0]  CtrlLSU = '0;
  logic        CtrlPCWriteback = 1'b0;
  logic [1:0]  CtrlPCMode = '0;
  logic [31:0] DecodedImm = '0, Rs1Data = '0, Rs2Data = '0, AluResult = '0, dmem_rdata = '0;
  logic        IntegerUnitFlag = 1'b0;
  logic        RegWrite, Retire, Halted;
  logic [1:0]  RdSrc;
  logic [31:0] PC;

  always #5 clk = ~clk;

  core_sequencer_if bus();

  core_sequencer dut (
    .clk(clk), .rst(rst), .mem(bus.master), .Inst(Inst), .CtrlLSU(CtrlLSU),
    .CtrlPCWriteback(CtrlPCWriteback), .CtrlPCMode(CtrlPCMode), .DecodedImm(DecodedImm),
    .Rs1Data(Rs1Data), .Rs2Data(Rs2Data), .AluResult(AluResult),
    .IntegerUnitFlag(IntegerUnitFlag), .RegWrite(RegWrite), .RdSrc(RdSrc), .PC(PC),
    .Retire(Retire), .Halted(Halted)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        rw;
    logic [31:0] wval;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  int          cyc = 0, last_ret = 0, gap = 0;
  logic        npc_pend = 1'b0;
  logic [31:0] npc_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Retirement monitor: it compares each retire against the next queued expectation.
  // On the following cycle it also checks the updated PC.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] wv;
    #2;
    if (npc_pend) begin
      total++;
      if (PC !== npc_exp) begin bad++; $display("FAIL next_pc: got %h want %h", PC, npc_exp); end
      npc_pend = 1'b0;
    end
    if (Retire === 1'b1) begin
      gap = cyc - last_ret;
      last_ret = cyc;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL retire_unexpected: got retire at pc %h want none", PC);
      end else begin
        e = sb.pop_front();
        total++;
        if (PC !== e.pc) begin bad++; $display("FAIL retire_pc: got %h want %h", PC, e.pc); end
        total++;
        if (RegWrite !== e.rw) begin bad++; $display("FAIL regwrite @%h: got %b want %b", e.pc, RegWrite, e.rw); end
        if (e.rw) begin
          wv = (RdSrc == 2'b00) ? AluResult : (RdSrc == 2'b01) ? dmem_rdata :
               (RdSrc == 2'b10) ? PC + 32'd2 : 32'hxxxx_xxxx;
          total++;
          if (wv !== e.wval) begin bad++; $display("FAIL wb_value @%h: got %h (src %b) want %h", e.pc, wv, RdSrc, e.wval); end
        end
        npc_exp  = e.npc;
        npc_pend = 1'b1;
      end
    end
  end

  // One instruction from FETCH to retire. The task starts and ends at negedge+1 while the DUT is in FETCH.
  task automatic run_instr(input logic [15:0] ins, input logic [3:0] lsu, input logic wb,
                           input logic [1:0] mode, input logic [31:0] imm, rs1, rs2, alu,
                           input logic flag, input int iwait, input int dwait, input logic [31:0] rdata,
                           input logic [31:0] epc, enpc, input logic rw, input logic [31:0] wval);
    exp_t e;
    int   k, hold;
    CtrlLSU = lsu; CtrlPCWriteback = wb; CtrlPCMode = mode; DecodedImm = imm;
    Rs1Data = rs1; Rs2Data = rs2; AluResult = alu; IntegerUnitFlag = flag;
    e.pc = epc; e.npc = enpc; e.rw = rw; e.wval = wval;
    sb.push_back(e);
    k = 0;
    while (bus.IMemReq !== 1'b1 && k < 50) begin @(negedge clk); #1; k++; end
    total++;
    if (bus.IMemReq !== 1'b1) begin bad++; $display("FAIL fetch_timeout @%h: got no IMemReq want 1", epc); return; end
    repeat (iwait) begin @(negedge clk); #1; end
    total++;
    if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== epc) begin
      bad++; $display("FAIL imem_addr: got req=%b addr=%h want req=1 addr=%h", bus.IMemReq, bus.IMemAddr, epc);
    end
    bus.IMemAck = 1'b1; bus.IMemData = ins;
    @(negedge clk); #1;
    bus.IMemAck = 1'b0;
    total++;
    if (Inst !== ins) begin bad++; $display("FAIL inst_latch: got %h want %h", Inst, ins); end
    if (lsu[1:0] != 2'b00) begin
      @(negedge clk); #1;
      total++;
      if ({bus.DMemAddr, bus.DMemWdata, bus.DMemWe, bus.DMemSize} !== {alu, rs2, lsu[2], lsu[1:0]}) begin
        bad++; $display("FAIL dmem_latch: got %h/%h/%b/%b want %h/%h/%b/%b", bus.DMemAddr, bus.DMemWdata,
                        bus.DMemWe, bus.DMemSize, alu, rs2, lsu[2], lsu[1:0]);
      end
      hold = 0;
      repeat (dwait - 1) begin
        if (bus.DMemReq === 1'b1) hold++;
        @(negedge clk); #1;
      end
      if (bus.DMemReq === 1'b1) hold++;
      total++;
      if (hold !== dwait) begin bad++; $display("FAIL dmem_req_hold: got %0d want %0d", hold, dwait); end
      bus.DMemAck = 1'b1; dmem_rdata = rdata;
      @(negedge clk); #1;
      bus.DMemAck = 1'b0;
    end else begin
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    total++;
    if ({bus.IMemReq, bus.DMemReq, RegWrite, Retire, Halted, PC, Inst} !== {5'b0, 32'h0, 16'h0001}) begin
      bad++; $display("FAIL reset_state: got req=%b dreq=%b rw=%b ret=%b halt=%b pc=%h inst=%h want 0 0 0 0 0 0 0001",
                      bus.IMemReq, bus.DMemReq, RegWrite, Retire, Halted, PC, Inst);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_instr(16'h4705, 4'h0, 0, 2'd0, 0, 0, 0, 32'd1, 0, 0, 0, 0, 32'h0, 32'h2, 1, 32'd1);
    run_instr(16'h4781, 4'h0, 0, 2'd0, 0, 0, 0, 32'd0, 0, 0, 0, 0, 32'h2, 32'h4, 1, 32'd0);
    run_instr(16'h97BA, 4'h0, 0, 2'd0, 0, 0, 0, 32'd1, 0, 0, 0, 0, 32'h4, 32'h6, 1, 32'd1);
    run_instr(16'h0705, 4'h0, 0, 2'd0, 0, 0, 0, 32'd2, 0, 0, 0, 0, 32'h6, 32'h8, 1, 32'd2);
    total++;
    if (gap !== 2) begin bad++; $display("FAIL retire_gap: got %0d want 2", gap); end
  endtask

  task automatic test_jumps;
    run_instr(16'hA021, 4'h0, 0, 2'd3, 32'd8, 0, 0, 0, 0, 0, 0, 0, 32'h08, 32'h10, 0, 0);
    run_instr(16'hA019, 4'h0, 0, 2'd3, 32'd6, 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h16, 0, 0);
    run_instr(16'h8082, 4'h0, 0, 2'd2, 0, 32'h20, 0, 0, 0, 0, 0, 0, 32'h16, 32'h20, 0, 0);
    run_instr(16'h2021, 4'h0, 1, 2'd3, 32'd8, 0, 0, 32'h55, 0, 0, 0, 0, 32'h20, 32'h28, 1, 32'h22);
  endtask

  task automatic test_branch;
    run_instr(16'h8402, 4'h0, 0, 2'd2, 0, 32'h40, 0, 0, 0, 0, 0, 0, 32'h28, 32'h40, 0, 0);
    run_instr(16'hDC75, 4'h0, 0, 2'd1, 32'hFFFF_FFFC, 0, 0, 0, 1, 0, 0, 0, 32'h40, 32'h3C, 0, 0);
    run_instr(16'hA011, 4'h0, 0, 2'd3, 32'd4, 0, 0, 0, 0, 0, 0, 0, 32'h3C, 32'h40, 0, 0);
    run_instr(16'hDC75, 4'h0, 0, 2'd1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 32'h40, 32'h42, 0, 0);
  endtask

  task automatic test_mem;
    run_instr(16'hC01C, 4'b0110, 0, 2'd0, 0, 0, 32'h1234_5678, 32'h100, 0, 0, 3, 0,
              32'h42, 32'h44, 0, 0);
    run_instr(16'h4044, 4'b0010, 0, 2'd0, 0, 0, 32'h0, 32'h104, 0, 1, 3, 32'hDEAD_BEEF,
              32'h44, 32'h46, 1, 32'hDEAD_BEEF);
  endtask

  task automatic test_pc_wrap;
    run_instr(16'h8402, 4'h0, 0, 2'd2, 0, 32'h101, 0, 0, 0, 0, 0, 0, 32'h46, 32'h100, 0, 0);
    run_instr(16'h8402, 4'h0, 0, 2'd2, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 32'h100, 32'hFFFF_FFFE, 0, 0);
    run_instr(16'h0001, 4'h0, 0, 2'd0, 0, 0, 0, 32'h9, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'h0, 0, 0);
    run_instr(16'h479D, 4'h0, 0, 2'd0, 0, 0, 0, 32'd7, 0, 3, 0, 0, 32'h0, 32'h2, 1, 32'd7);
  endtask

  task automatic test_reset_stall;
    repeat (2) begin @(negedge clk); #1; end
    total++;
    if (bus.IMemReq !== 1'b1 || PC !== 32'h2) begin bad++; $display("FAIL stall_fetch: got req=%b pc=%h want 1 00000002", bus.IMemReq, PC); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.IMemReq !== 1'b0 || PC !== 32'h0) begin bad++; $display("FAIL rst_fetch: got req=%b pc=%h want 0 00000000", bus.IMemReq, PC); end
    @(negedge clk); #1; rst = 1'b0;
    CtrlLSU = 4'b0010; AluResult = 32'h200;
    bus.IMemAck = 1'b1; bus.IMemData = 16'h4044;
    @(negedge clk); #1; bus.IMemAck = 1'b0;
    @(negedge clk); #1;
    total++;
    if (bus.DMemReq !== 1'b1) begin bad++; $display("FAIL stall_load: got dreq=%b want 1", bus.DMemReq); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.DMemReq, bus.IMemReq, PC} !== {2'b00, 32'h0}) begin
      bad++; $display("FAIL rst_load: got dreq=%b ireq=%b pc=%h want 0 0 00000000", bus.DMemReq, bus.IMemReq, PC);
    end
    bus.DMemAck = 1'b1;
    @(negedge clk); #1; rst = 1'b0;
    @(negedge clk); #1; bus.DMemAck = 1'b0;
    total++;
    if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h0 || bus.DMemReq !== 1'b0) begin
      bad++; $display("FAIL late_ack: got ireq=%b addr=%h dreq=%b want 1 00000000 0", bus.IMemReq, bus.IMemAddr, bus.DMemReq);
    end
  endtask

  task automatic test_halt;
    int reqs;
    CtrlLSU = 4'h0;
    bus.IMemAck = 1'b1; bus.IMemData = 16'h9002;
    @(negedge clk); #1; bus.IMemAck = 1'b0;
    @(negedge clk); #1;
    total++;
    if (Halted !== 1'b1 || PC !== 32'h0) begin bad++; $display("FAIL halt: got halted=%b pc=%h want 1 00000000", Halted, PC); end
    reqs = 0;
    bus.IMemAck = 1'b1;
    repeat (5) begin
      if (bus.IMemReq !== 1'b0 || bus.DMemReq !== 1'b0) reqs++;
      @(negedge clk); #1;
    end
    bus.IMemAck = 1'b0;
    total++;
    if (reqs !== 0 || Halted !== 1'b1) begin bad++; $display("FAIL halt_quiet: got %0d req cycles halted=%b want 0 1", reqs, Halted); end
  endtask

  initial begin
    bus.IMemAck = 1'b0; bus.IMemData = '0; bus.DMemAck = 1'b0;
    test_reset();
    test_basic();
    test_jumps();
    test_branch();
    test_mem();
    test_pc_wrap();
    test_reset_stall();
    test_halt();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d pending want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
